mod_arith_v_seq: RTL and testbench

//  Command sequencer for the ECC V register (SETX/TCAST/SETU/SWAP datapath with RSD-to-binary unit).

---
 rtl/mod_arith_pkg.sv | 35 +++
 rtl/mod_arith_v_seq_if.sv | 25 ++
 rtl/mod_arith_cmd_fifo.sv | 57 +++++
 rtl/mod_arith_v_seq.sv | 156 +++++++++++++++
 tb/tb_mod_arith_v_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the ECC V-register command sequencer: micro-op
// codes, sequencer state encoding and the control part of a queued command.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        OP_V_SETX  = 2'b00,
        OP_V_TCAST = 2'b01,
        OP_V_SETU  = 2'b10,
        OP_V_SWAP  = 2'b11
    } v_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_ACK = 2'b01,
        ST_WAIT_RTB = 2'b10,
        ST_RECOVER  = 2'b11
    } seq_state_e;

    // Control fields of a queued command; the tag is appended separately
    // because its width is a module parameter.
    typedef struct packed {
        v_op_e op;
        logic  clr;
        logic  accv;
        logic  md;
    } cmd_ctl_t;

    localparam int CMD_CTL_W = $bits(cmd_ctl_t);

    // Only a real TCAST starts an RTB conversion; a clear ignores the op.
    function automatic logic is_long_op(input cmd_ctl_t c);
        return !c.clr && (c.op == OP_V_TCAST);
    endfunction

endpackage

// File: rtl/mod_arith_v_seq_if.sv
// Command/completion bus between the ECC top-level controller (master)
// and the V-register sequencer (slave).
interface mod_arith_v_seq_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_clr;
    logic             cmd_accv;
    logic             cmd_mod;
    logic [TAG_W-1:0] cmd_tag;
    logic             done;
    logic [TAG_W-1:0] done_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_clr, cmd_accv, cmd_mod, cmd_tag,
        input  cmd_ready, done, done_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_clr, cmd_accv, cmd_mod, cmd_tag,
        output cmd_ready, done, done_tag
    );
endinterface

// File: rtl/mod_arith_cmd_fifo.sv
// Small synchronous command FIFO with flush; the head entry is readable
// combinationally whenever head_valid is high.
module mod_arith_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == (AW+1)'(DEPTH));
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign do_push    = push && !full && !flush;
    assign do_pop     = pop && head_valid && !flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries only data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/mod_arith_v_seq.sv
// V-register command sequencer: queues micro-ops, issues them one at a
// time, holds the source/modulus selects across an RTB conversion, returns
// a tagged done and recovers a hung conversion via a watchdog.
module mod_arith_v_seq
    import mod_arith_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int MAX_WAIT = 24
) (
    input  logic                clk,
    input  logic                rst,
    mod_arith_v_seq_if.slave    cmd,
    input  logic                abort,
    output logic [1:0]          v_op,
    output logic                v_en,
    output logic                v_clr,
    output logic                opt_accv,
    output logic                flg_mod,
    input  logic                v_busy,
    output logic                seq_busy,
    output logic                err
);
    localparam int ENTRY_W = CMD_CTL_W + TAG_W;
    localparam int TW      = $clog2(MAX_WAIT);

    seq_state_e       state_q, state_d;
    logic [ENTRY_W-1:0] head_data;
    cmd_ctl_t         head_ctl;
    logic [TAG_W-1:0] head_tag;
    logic             head_valid;
    logic             full;
    logic             push;
    logic             issue;
    logic             done_set;
    logic [TAG_W-1:0] done_tag_d;
    logic             err_set;
    logic [TW-1:0]    timer_q;
    logic             accv_q, mod_q, done_q, err_q;
    logic [TAG_W-1:0] tag_q, done_tag_q;

    assign cmd.cmd_ready = !full && !abort;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign {head_ctl, head_tag} = head_data;

    mod_arith_cmd_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort),
        .push       (push),
        .push_data  ({cmd.cmd_op, cmd.cmd_clr, cmd.cmd_accv, cmd.cmd_mod, cmd.cmd_tag}),
        .pop        (issue),
        .head_data  (head_data),
        .head_valid (head_valid),
        .full       (full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state, issue strobes and completion/error decisions.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        v_en       = 1'b0;
        v_clr      = 1'b0;
        v_op       = OP_V_SETX;
        done_set   = 1'b0;
        done_tag_d = tag_q;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_valid && !abort) begin
                    issue = 1'b1;
                    if (head_ctl.clr) begin
                        v_clr = 1'b1;
                    end else begin
                        v_en = 1'b1;
                        v_op = head_ctl.op;
                    end
                    if (is_long_op(head_ctl)) begin
                        state_d = ST_WAIT_ACK;
                    end else begin
                        done_set   = 1'b1;
                        done_tag_d = head_tag;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (abort) begin
                    state_d = ST_RECOVER;
                end else if (v_busy) begin
                    state_d = ST_WAIT_RTB;
                end else begin
                    err_set = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            ST_WAIT_RTB: begin
                if (abort) begin
                    state_d = ST_RECOVER;
                end else if (!v_busy) begin
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end else if (timer_q == TW'(MAX_WAIT - 1)) begin
                    err_set = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                v_clr   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Watchdog: counts cycles spent in WAIT_RTB, zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       timer_q <= '0;
        else if (state_q != ST_WAIT_RTB) timer_q <= '0;
        else                           timer_q <= timer_q + TW'(1);
    end

    // Held selects, in-flight tag, done pulse and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accv_q     <= 1'b0;
            mod_q      <= 1'b0;
            tag_q      <= '0;
            done_q     <= 1'b0;
            done_tag_q <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q <= done_set;
            if (done_set) done_tag_q <= done_tag_d;
            if (issue) begin
                accv_q <= head_ctl.accv;
                mod_q  <= head_ctl.md;
                tag_q  <= head_tag;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    // Selects follow the head in the issue cycle, then hold until next issue.
    assign opt_accv     = issue ? head_ctl.accv : accv_q;
    assign flg_mod      = issue ? head_ctl.md   : mod_q;
    assign cmd.done     = done_q;
    assign cmd.done_tag = done_tag_q;
    assign err          = err_q;
    assign seq_busy     = head_valid || (state_q != ST_IDLE);
endmodule

// File: tb/tb_mod_arith_v_seq.sv
// Directed bench for the V-register sequencer with a behavioural RTB busy model.
module tb_mod_arith_v_seq;
    logic clk = 1'b0;
    logic rst;
    logic abort;
    logic [1:0] v_op;
    logic v_en, v_clr, opt_accv, flg_mod, v_busy, seq_busy, err;

    always #5 clk = ~clk;

    mod_arith_v_seq_if #(.TAG_W(4)) bus ();

    mod_arith_v_seq #(.DEPTH(4), .TAG_W(4), .MAX_WAIT(24)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (bus.slave),
        .abort    (abort),
        .v_op     (v_op),
        .v_en     (v_en),
        .v_clr    (v_clr),
        .opt_accv (opt_accv),
        .flg_mod  (flg_mod),
        .v_busy   (v_busy),
        .seq_busy (seq_busy),
        .err      (err)
    );

    // RTB model: a TCAST issue makes busy high for busy_len cycles from the next cycle.
    int   busy_left = 0;
    int   busy_len  = 8;
    logic stuck     = 1'b0;
    always @(posedge clk) begin
        if (v_clr)                          busy_left <= 0;
        else if (v_en && v_op == 2'b01)     busy_left <= busy_len;
        else if (busy_left > 0)             busy_left <= busy_left - 1;
    end
    assign v_busy = stuck || (busy_left != 0);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [1:0] op, input logic clr,
                         input logic accv, input logic md, input logic [3:0] tag);
        bus.cmd_valid = vld;
        bus.cmd_op    = op;
        bus.cmd_clr   = clr;
        bus.cmd_accv  = accv;
        bus.cmd_mod   = md;
        bus.cmd_tag   = tag;
    endtask

    task automatic quiet(input int n);
        drive(0, 2'b00, 0, 0, 0, 4'd0);
        for (int i = 0; i < n; i++) nxt();
    endtask

    typedef struct {
        logic [1:0] op;
        logic       clr, accv, md;
        logic [3:0] tag;
        logic       e_en, e_clr;
        logic [1:0] e_op;
        logic       e_accv, e_mod;
    } vec_t;

    vec_t vt[5];
    int   ndone, nclr;
    logic [3:0] exp_tags[5];

    initial begin
        vt[0] = '{2'b00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vt[1] = '{2'b10, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1};
        vt[2] = '{2'b11, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1};
        vt[3] = '{2'b01, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vt[4] = '{2'b00, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};

        rst = 1'b1;
        abort = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 4'd0);
        nxt(); nxt();
        #1;
        chk("rst_v_en", v_en, 0);
        chk("rst_v_clr", v_clr, 0);
        chk("rst_v_op", v_op, 0);
        chk("rst_accv", opt_accv, 0);
        chk("rst_mod", flg_mod, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_tag", bus.done_tag, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", seq_busy, 0);
        rst = 1'b0;
        quiet(3);

        // Single-issue commands from the table.
        foreach (vt[i]) begin
            drive(1, vt[i].op, vt[i].clr, vt[i].accv, vt[i].md, vt[i].tag);
            #1; chk("tbl_ready", bus.cmd_ready, 1);
            nxt();
            drive(0, 2'b00, 0, 0, 0, 4'd0);
            #1;
            chk("tbl_v_en", v_en, vt[i].e_en);
            chk("tbl_v_clr", v_clr, vt[i].e_clr);
            chk("tbl_v_op", v_op, vt[i].e_op);
            chk("tbl_accv", opt_accv, vt[i].e_accv);
            chk("tbl_mod", flg_mod, vt[i].e_mod);
            nxt(); #1;
            chk("tbl_done", bus.done, 1);
            chk("tbl_done_tag", bus.done_tag, vt[i].tag);
            chk("tbl_idle_en", v_en | v_clr, 0);
            chk("tbl_hold_accv", opt_accv, vt[i].e_accv);
            chk("tbl_hold_mod", flg_mod, vt[i].e_mod);
            nxt(); #1;
            chk("tbl_done_off", bus.done, 0);
            chk("tbl_seq_busy", seq_busy, 0);
            nxt();
        end

        // Back-to-back SETX tag 1, SETU tag 2.
        drive(1, 2'b00, 0, 0, 0, 4'd1); #1;
        nxt();
        drive(1, 2'b10, 0, 0, 0, 4'd2); #1;
        chk("b2b_en1", v_en, 1); chk("b2b_op1", v_op, 0);
        nxt();
        drive(0, 2'b00, 0, 0, 0, 4'd0); #1;
        chk("b2b_en2", v_en, 1); chk("b2b_op2", v_op, 2);
        chk("b2b_done1", bus.done, 1); chk("b2b_tag1", bus.done_tag, 1);
        nxt(); #1;
        chk("b2b_done2", bus.done, 1); chk("b2b_tag2", bus.done_tag, 2);
        chk("b2b_en_off", v_en, 0);
        nxt(); #1;
        chk("b2b_done_off", bus.done, 0);
        quiet(2);

        // TCAST mod=1, 8-cycle conversion.
        busy_len = 8;
        drive(1, 2'b01, 0, 0, 1, 4'd3); #1;
        for (int k = 1; k <= 12; k++) begin
            nxt();
            if (k == 1) drive(0, 2'b00, 0, 0, 0, 4'd0);
            #1;
            if (k == 1) begin
                chk("tc8_en", v_en, 1); chk("tc8_op", v_op, 1);
            end
            if (k <= 10) begin
                chk("tc8_mod_hold", flg_mod, 1);
                chk("tc8_no_done", bus.done, 0);
            end
            if (k == 11) begin
                chk("tc8_done", bus.done, 1); chk("tc8_tag", bus.done_tag, 3);
            end
        end
        chk("tc8_err", err, 0);
        chk("tc8_seq_busy", seq_busy, 0);
        quiet(2);

        // TCAST with underflow pass, 16-cycle conversion.
        busy_len = 16;
        drive(1, 2'b01, 0, 1, 0, 4'd4); #1;
        for (int k = 1; k <= 20; k++) begin
            nxt();
            if (k == 1) drive(0, 2'b00, 0, 0, 0, 4'd0);
            #1;
            if (k <= 18) begin
                chk("tc16_no_done", bus.done, 0);
                chk("tc16_accv_hold", opt_accv, 1);
            end
            if (k == 19) begin
                chk("tc16_done", bus.done, 1); chk("tc16_tag", bus.done_tag, 4);
            end
        end
        chk("tc16_err", err, 0);
        quiet(2);

        // Fill the FIFO behind an in-flight TCAST.
        busy_len = 8;
        drive(1, 2'b01, 0, 0, 0, 4'd5); #1; nxt();
        drive(1, 2'b00, 0, 0, 0, 4'd6); #1; nxt();
        drive(1, 2'b11, 0, 0, 0, 4'd7); #1; nxt();
        drive(1, 2'b10, 1, 0, 0, 4'd8); #1; nxt();
        drive(1, 2'b10, 0, 0, 0, 4'd9); #1; nxt();
        drive(1, 2'b00, 0, 0, 0, 4'd10); #1;
        chk("full_ready", bus.cmd_ready, 0);
        nxt();
        drive(0, 2'b00, 0, 0, 0, 4'd0);
        exp_tags = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        for (int k = 6; k <= 17; k++) begin
            #1;
            if (k <= 11) chk("full_ready_hold", bus.cmd_ready, 0);
            if (k == 12) chk("full_ready_back", bus.cmd_ready, 1);
            if (k >= 11 && k <= 15) begin
                chk("full_done", bus.done, 1);
                chk("full_order", bus.done_tag, exp_tags[k-11]);
            end else begin
                chk("full_no_done", bus.done, 0);
            end
            nxt();
        end
        quiet(2);

        // Conversion that never finishes: watchdog.
        stuck = 1'b1;
        ndone = 0; nclr = 0;
        drive(1, 2'b01, 0, 0, 0, 4'd11); #1;
        for (int k = 1; k <= 31; k++) begin
            nxt();
            if (k == 1) drive(0, 2'b00, 0, 0, 0, 4'd0);
            #1;
            if (bus.done) ndone++;
            if (v_clr) nclr++;
            if (k == 20) chk("wd_err_early", err, 0);
        end
        chk("wd_err", err, 1);
        chk("wd_clr_pulses", nclr, 1);
        chk("wd_no_done", ndone, 0);
        stuck = 1'b0;
        quiet(2);
        drive(1, 2'b00, 0, 0, 0, 4'd12); #1; nxt();
        drive(0, 2'b00, 0, 0, 0, 4'd0); #1;
        chk("wd_next_en", v_en, 1);
        nxt(); #1;
        chk("wd_next_done", bus.done, 1); chk("wd_next_tag", bus.done_tag, 12);
        chk("wd_err_sticky", err, 1);
        quiet(2);

        // Abort during WAIT_RTB with two commands queued.
        busy_len = 8;
        ndone = 0; nclr = 0;
        drive(1, 2'b01, 0, 0, 0, 4'd13); #1; nxt();
        drive(1, 2'b00, 0, 0, 0, 4'd14); #1; nxt();
        drive(1, 2'b10, 0, 0, 0, 4'd15); #1; nxt();
        drive(0, 2'b00, 0, 0, 0, 4'd0); #1; nxt();
        #1; nxt();
        abort = 1'b1;
        drive(1, 2'b00, 0, 0, 0, 4'd0); #1;
        chk("ab_ready", bus.cmd_ready, 0);
        nxt();
        abort = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 4'd0); #1;
        chk("ab_clr", v_clr, 1);
        chk("ab_busy1", seq_busy, 1);
        nxt(); #1;
        chk("ab_busy2", seq_busy, 0);
        for (int k = 0; k < 10; k++) begin
            if (bus.done) ndone++;
            if (v_clr || v_en) nclr++;
            nxt(); #1;
        end
        chk("ab_no_done", ndone, 0);
        chk("ab_no_issue", nclr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
